// File: rtl/fifo_pkg.sv
// Shared helpers and defaults for the sync_fifo block.
package fifo_pkg;

    // Default almost_full threshold is DEPTH minus this offset.
    localparam int DEF_AF_OFFSET = 2;
    // Default almost_empty threshold.
    localparam int DEF_AE_TH     = 1;

    // Entry index width for a given depth (never narrower than one bit).
    function automatic int fifo_addr_len(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage with a registered read port.
// The array itself is never reset; only the read register is.
module fifo_ram #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_LEN  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [ADDR_LEN-1:0]  waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_LEN-1:0]  raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);

    localparam int ENTRIES = 1 << ADDR_LEN;

    logic [DATA_SIZE-1:0] mem_q [ENTRIES];
    logic [DATA_SIZE-1:0] rdata_q;

    // Write port: store the word at the write index.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read port: capture the addressed word; hold the last value otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port, occupancy count,
// full/empty and programmable almost flags, and synchronous flush.
// Optional sticky overflow/underflow outputs: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter  int DATA_SIZE = 32,
    parameter  int DEPTH     = 32,
    parameter  int AF_TH     = DEPTH - DEF_AF_OFFSET,
    parameter  int AE_TH     = DEF_AE_TH,
    localparam int ADDR_LEN  = fifo_addr_len(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 w_en,
    input  logic [DATA_SIZE-1:0] w_data,
    input  logic                 r_en,
    output logic [DATA_SIZE-1:0] r_data,
    output logic                 r_valid,
    output logic                 w_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_LEN:0]    count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 underflow
`endif
);

    // Pointers carry an extra wrap bit so they run modulo 2*DEPTH.
    typedef logic [ADDR_LEN:0] ptr_t;

    localparam ptr_t ONE_C   = ptr_t'(1);
    localparam ptr_t DEPTH_C = ptr_t'(DEPTH);
    localparam ptr_t AF_C    = ptr_t'(AF_TH);
    localparam ptr_t AE_C    = ptr_t'(AE_TH);

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t count_q,  count_d;
    logic w_valid_q, r_valid_q;
    logic wr_acc, rd_acc;

    // Flags decode the registered count, so they never glitch.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign w_valid      = w_valid_q;
    assign r_valid      = r_valid_q;

    // Acceptance uses start-of-cycle full/empty; flush overrides both.
    assign wr_acc = w_en & ~full  & ~flush;
    assign rd_acc = r_en & ~empty & ~flush;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset aborts anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            w_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            w_valid_q <= wr_acc;
            r_valid_q <= rd_acc;
        end
    end

    fifo_ram #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_LEN  (ADDR_LEN)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_LEN-1:0]),
        .wdata_i (w_data),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[ADDR_LEN-1:0]),
        .rdata_o (r_data)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky error flags: set on a rejected request, cleared by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (w_en & full);
            underflow_q <= underflow_q | (r_en & empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
